// File: rtl/interpolate_pkg.sv
// Shared rate-change package for the interpolator / decimator pair.
//   DEF_W      default sample width in bits
//   state_e    handshake state of the interpolator
//   cnt_width  beat/phase counter width, max(1, clog2(n))
package interpolate_pkg;

  localparam int DEF_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // A factor of 1 or 2 still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/interpolate.sv
// Integer upsampler by factor L with stb/rdy handshakes on both sides.
// Each accepted sample becomes L output beats. Beat 0 carries the sample.
// Beats 1..L-1 carry zero (zero-stuffing, ahead of an image-reject filter),
// or repeat the sample when INTERPOLATE_HOLD_EN is defined (zero-order hold).
// Handshake, m_fst and timing are identical in both builds.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   s_stb  in   upstream sample valid
//   s_dat  in   upstream sample [W-1:0]
//   s_rdy  out  block accepts a sample this cycle
//   m_rdy  in   downstream ready
//   m_stb  out  output beat valid
//   m_dat  out  output beat data [W-1:0]
//   m_fst  out  high on beat 0 of each group of L
//
// state | meaning
// IDLE  | no group in flight, s_rdy high
// EMIT  | emitting beats cnt_q = 0..L-1 of the sample in smp_q
module interpolate
  import interpolate_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int L = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_stb,
  input  logic [W-1:0] s_dat,
  output logic         s_rdy,
  input  logic         m_rdy,
  output logic         m_stb,
  output logic [W-1:0] m_dat,
  output logic         m_fst
);

  localparam int            CW       = cnt_width(L);
  localparam logic [CW-1:0] LAST_CNT = CW'(L - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  smp_q;

  logic busy;
  logic last;
  logic in_xfer;
  logic out_xfer;

  assign busy     = (state_q == EMIT);
  assign last     = (cnt_q == LAST_CNT);
  // The next sample is taken on the same edge as the final beat, so groups
  // follow each other without a bubble.
  assign s_rdy    = ~busy | (m_rdy & last);
  assign in_xfer  = s_stb & s_rdy;
  assign out_xfer = busy & m_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      smp_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_xfer) begin
            state_q <= EMIT;
            smp_q   <= s_dat;
            cnt_q   <= '0;
          end
        end
        EMIT: begin
          if (out_xfer) begin
            if (!last) begin
              cnt_q <= cnt_q + CW'(1);
            end else begin
              // Explicit wrap: the only wrap path for non-power-of-two L.
              cnt_q <= '0;
              if (in_xfer) smp_q   <= s_dat;
              else         state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only, so they hold steady under stall.
  assign m_stb = busy;
  assign m_fst = busy & (cnt_q == '0);
`ifdef INTERPOLATE_HOLD_EN
  assign m_dat = smp_q;
`else
  assign m_dat = (cnt_q == '0) ? smp_q : '0;
`endif

endmodule

// File: tb/tb_interpolate.sv
// Bench for interpolate: four instances (L = 4, 3, 1, 5) share clk/rst.
// Drivers push expected beats into per-instance queues on input accept; a
// monitor pops and compares on every output transfer.
module tb_interpolate;

  logic        clk;
  logic        rst;
  logic        s_stb [4];
  logic [15:0] s_dat [4];
  logic        s_rdy [4];
  logic        m_rdy [4];
  logic        m_stb [4];
  logic [15:0] m_dat [4];
  logic        m_fst [4];

`ifdef INTERPOLATE_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  interpolate #(.W(16), .L(4)) u_l4 (
    .clk(clk), .rst(rst), .s_stb(s_stb[0]), .s_dat(s_dat[0]), .s_rdy(s_rdy[0]),
    .m_rdy(m_rdy[0]), .m_stb(m_stb[0]), .m_dat(m_dat[0]), .m_fst(m_fst[0]));
  interpolate #(.W(16), .L(3)) u_l3 (
    .clk(clk), .rst(rst), .s_stb(s_stb[1]), .s_dat(s_dat[1]), .s_rdy(s_rdy[1]),
    .m_rdy(m_rdy[1]), .m_stb(m_stb[1]), .m_dat(m_dat[1]), .m_fst(m_fst[1]));
  interpolate #(.W(16), .L(1)) u_l1 (
    .clk(clk), .rst(rst), .s_stb(s_stb[2]), .s_dat(s_dat[2]), .s_rdy(s_rdy[2]),
    .m_rdy(m_rdy[2]), .m_stb(m_stb[2]), .m_dat(m_dat[2]), .m_fst(m_fst[2]));
  interpolate #(.W(16), .L(5)) u_l5 (
    .clk(clk), .rst(rst), .s_stb(s_stb[3]), .s_dat(s_dat[3]), .s_rdy(s_rdy[3]),
    .m_rdy(m_rdy[3]), .m_stb(m_stb[3]), .m_dat(m_dat[3]), .m_fst(m_fst[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [16:0] exp_q [4][$];   // {fst, dat}
  int          t0_q [$];       // cycle stamps of L=4 output transfers
  int          beats1 = 0;     // L=3 output transfer count
  logic [15:0] rec1 [$];       // L=3 beat-0 values (decimate-by-3 model)

  always @(posedge clk) cyc++;

  function automatic int lval(input int i);
    case (i)
      0:       return 4;
      1:       return 3;
      2:       return 1;
      default: return 5;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int i, input logic [15:0] d);
    for (int k = 0; k < lval(i); k++)
      exp_q[i].push_back({(k == 0), ((k == 0) || HOLD) ? d : 16'h0000});
  endtask

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    logic [16:0] e;
    for (int i = 0; i < 4; i++) begin
      if (!rst && m_stb[i] && m_rdy[i]) begin
        if (exp_q[i].size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected inst=%0d: got dat=%0h fst=%0b required no beat",
                   i, m_dat[i], m_fst[i]);
        end else begin
          e = exp_q[i].pop_front();
          chk($sformatf("beat inst=%0d {fst,dat}", i), {15'h0, m_fst[i], m_dat[i]}, {15'h0, e});
        end
        if (i == 0) t0_q.push_back(cyc);
        if (i == 1) begin
          beats1++;
          if (m_fst[i]) rec1.push_back(m_dat[i]);
        end
      end
    end
  end

  // One cycle of stimulus on instance i; returns whether the sample was taken.
  task automatic step(input int i, input logic stb, input logic [15:0] d,
                      input logic rdy, output logic acc);
    @(posedge clk);
    #1;
    s_stb[i] = stb;
    s_dat[i] = d;
    m_rdy[i] = rdy;
    @(negedge clk);
    acc = stb & s_rdy[i];
    if (acc) push_exp(i, d);
  endtask

  task automatic send(input int i, input logic [15:0] d, input int stall_pct);
    logic acc;
    int   tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      step(i, 1'b1, d, ($urandom_range(99) >= stall_pct), acc);
      tries++;
    end
    if (!acc) chk("send_accept_timeout", {31'h0, acc}, 32'h1);
  endtask

  task automatic drain(input int i, input int stall_pct);
    logic acc;
    int   n;
    n = 0;
    step(i, 1'b0, 16'($urandom), 1'b1, acc);
    while (exp_q[i].size() > 0 && n < 500) begin
      step(i, 1'b0, 16'($urandom), ($urandom_range(99) >= stall_pct), acc);
      n++;
    end
    chk($sformatf("drain_left inst=%0d", i), exp_q[i].size(), 0);
  endtask

  logic        acc;
  logic [15:0] in_list [$];
  logic [15:0] vec [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      s_stb[i] = 1'b0;
      s_dat[i] = 16'h0;
      m_rdy[i] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset m_stb inst=%0d", i), {31'h0, m_stb[i]}, 32'h0);
      chk($sformatf("reset m_fst inst=%0d", i), {31'h0, m_fst[i]}, 32'h0);
      chk($sformatf("reset m_dat inst=%0d", i), {16'h0, m_dat[i]}, 32'h0);
      chk($sformatf("reset s_rdy inst=%0d", i), {31'h0, s_rdy[i]}, 32'h1);
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic L=4, back-to-back 0x0011, 0x0022, m_rdy=1.
    t0_q.delete();
    step(0, 1'b1, 16'h0011, 1'b1, acc);
    chk("basic first accept", {31'h0, acc}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      step(0, 1'b1, 16'h0022, 1'b1, acc);
      chk($sformatf("basic s_rdy beat%0d", k), {31'h0, s_rdy[0]}, (k == 3) ? 32'h1 : 32'h0);
      if (k == 0) chk("basic m_fst beat0", {31'h0, m_fst[0]}, 32'h1);
      if (k == 1) chk("basic m_dat beat1", {16'h0, m_dat[0]}, HOLD ? 32'h11 : 32'h0);
    end
    drain(0, 0);
    chk("basic beat count", t0_q.size(), 8);
    if (t0_q.size() == 8) chk("basic no bubbles", t0_q[7] - t0_q[0], 7);

    // Backpressure L=3, 0x1234, m_rdy 1,0,0,1,1.
    beats1 = 0;
    step(1, 1'b1, 16'h1234, 1'b1, acc);
    chk("bp accept", {31'h0, acc}, 32'h1);
    begin
      logic rdy_pat [5];
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      for (int k = 0; k < 5; k++) begin
        step(1, 1'b0, 16'hDEAD, rdy_pat[k], acc);
        chk($sformatf("bp s_rdy c%0d", k), {31'h0, s_rdy[1]}, (k == 4) ? 32'h1 : 32'h0);
        chk($sformatf("bp m_stb c%0d", k), {31'h0, m_stb[1]}, 32'h1);
        if (k == 1 || k == 2) begin
          chk($sformatf("bp stall m_dat c%0d", k), {16'h0, m_dat[1]}, HOLD ? 32'h1234 : 32'h0);
          chk($sformatf("bp stall m_fst c%0d", k), {31'h0, m_fst[1]}, 32'h0);
        end
      end
    end
    drain(1, 0);
    chk("bp beat count", beats1, 3);

    // Single 0xBEEF on L=3 (repeats in the hold build, zeros otherwise).
    send(1, 16'hBEEF, 0);
    step(1, 1'b0, 16'h0, 1'b1, acc);
    chk("beef beat0 dat", {16'h0, m_dat[1]}, 32'hBEEF);
    chk("beef beat0 fst", {31'h0, m_fst[1]}, 32'h1);
    drain(1, 0);

    // L=1: latency and full rate, then random samples under random stalls.
    vec = '{16'hA5A5, 16'h0001, 16'hFFFF, 16'h7E81};
    for (int k = 0; k < 5; k++) begin
      step(2, (k < 4), (k < 4) ? vec[(k < 4) ? k : 0] : 16'h0, 1'b1, acc);
      if (k < 4) chk($sformatf("l1 full-rate accept %0d", k), {31'h0, acc}, 32'h1);
      if (k > 0) begin
        chk($sformatf("l1 latency m_dat %0d", k), {16'h0, m_dat[2]}, {16'h0, vec[k-1]});
        chk($sformatf("l1 m_fst %0d", k), {31'h0, m_fst[2]}, 32'h1);
      end
    end
    drain(2, 0);
    for (int k = 0; k < 8; k++) send(2, 16'($urandom), 40);
    drain(2, 40);

    // Reset mid-group on L=5.
    send(3, 16'h00AA, 0);
    for (int k = 0; k < 3; k++) step(3, 1'b0, 16'h0, 1'b1, acc);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) s_stb[i] = 1'b0;
    m_rdy[3] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q[3].delete();
    @(negedge clk);
    chk("rst-mid m_stb", {31'h0, m_stb[3]}, 32'h0);
    chk("rst-mid s_rdy", {31'h0, s_rdy[3]}, 32'h1);
    send(3, 16'h00BB, 0);
    step(3, 1'b0, 16'h0, 1'b1, acc);
    chk("rst-mid fresh dat", {16'h0, m_dat[3]}, 32'hBB);
    chk("rst-mid fresh fst", {31'h0, m_fst[3]}, 32'h1);
    drain(3, 0);

    // L=3, 100 random samples with random stalls; decimate-by-3 recovers input.
    beats1 = 0;
    rec1.delete();
    in_list.delete();
    for (int k = 0; k < 100; k++) begin
      logic [15:0] d;
      d = 16'($urandom);
      in_list.push_back(d);
      send(1, d, 30);
    end
    drain(1, 30);
    chk("rand beat count", beats1, 300);
    chk("rand group count", rec1.size(), 100);
    if (rec1.size() == 100)
      for (int k = 0; k < 100; k++)
        chk($sformatf("rand decimated %0d", k), {16'h0, rec1[k]}, {16'h0, in_list[k]});

    for (int i = 0; i < 4; i++)
      chk($sformatf("final queue inst=%0d", i), exp_q[i].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
